// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences a two-half-adder cell plus carry flop
// over a WIDTH-bit operand pair, LSB first, and publishes a WIDTH+1-bit sum.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     sum_q, sum_d;

  logic               s1, c1, sum_bit, c2, carry_nxt, last_bit;
  logic [WIDTH-1:0]   acc_shift;

  // One-bit add cell: two cascaded half adders feeding the carry flop
  assign s1        = a_sh_q[0] ^ b_sh_q[0];
  assign c1        = a_sh_q[0] & b_sh_q[0];
  assign sum_bit   = s1 ^ carry_q;
  assign c2        = s1 & carry_q;
  assign carry_nxt = c1 | c2;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign acc_shift = sum_bit;
    end else begin : g_acc_wn
      assign acc_shift = {sum_bit, acc_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = acc_shift;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) sum_d = {carry_nxt, acc_shift};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum_out = sum_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit and a 1-bit instance share
// clock and reset; expected sums are hand-computed constants.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8;
  logic [8:0] sum8;
  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [1:0] sum1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .sum_out(sum8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .sum_out(sum1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit add: latency, result, busy width, and clean return to idle
  task automatic run_add8(input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] exp, input string tag);
    int lat;
    int busy_cnt;
    bit seen;
    a8 = a; b8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hC3; b8 = 8'h3C;
    busy_cnt = int'(busy8);
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (busy8) busy_cnt++;
      if (done8) begin
        seen = 1'b1;
        lat = k;
      end
    end
    check_eq({tag, " latency"}, 32'(lat), 32'd8);
    check_eq({tag, " sum"}, 32'(sum8), 32'(exp));
    check_eq({tag, " busy_len"}, 32'(busy_cnt), 32'd9);
    tick();
    check_eq({tag, " done_fall"}, 32'(done8), 32'd0);
    check_eq({tag, " busy_fall"}, 32'(busy8), 32'd0);
    check_eq({tag, " sum_hold"}, 32'(sum8), 32'(exp));
  endtask

  initial begin
    int lat;
    bit seen;
    int extra_done;
    int extra_busy;
    logic [1:0] exp1;

    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle busy8", 32'(busy8), 32'd0);
      check_eq("idle done8", 32'(done8), 32'd0);
      check_eq("idle sum8", 32'(sum8), 32'd0);
      check_eq("idle busy1", 32'(busy1), 32'd0);
      check_eq("idle sum1", 32'(sum1), 32'd0);
    end

    run_add8(8'h5A, 8'h33, 9'h08D, "5A+33");
    run_add8(8'hFF, 8'h01, 9'h100, "FF+01");
    run_add8(8'hFF, 8'hFF, 9'h1FE, "FF+FF");
    run_add8(8'h00, 8'h00, 9'h000, "00+00");

    // Requests during ADD and DONE are dropped
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (done8) begin
        seen = 1'b1;
        lat = k;
        a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
      end else if (k == 3) begin
        a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    check_eq("drop latency", 32'(lat), 32'd8);
    check_eq("drop sum", 32'(sum8), 32'h030);
    tick();
    start8 = 1'b0;
    check_eq("drop done_fall", 32'(done8), 32'd0);
    check_eq("drop busy_fall", 32'(busy8), 32'd0);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) extra_done++;
      if (busy8) extra_busy++;
    end
    check_eq("drop extra_done", 32'(extra_done), 32'd0);
    check_eq("drop extra_busy", 32'(extra_busy), 32'd0);
    check_eq("drop sum_hold", 32'(sum8), 32'h030);

    // Reset in the middle of ADD discards the partial result
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    check_eq("rst pre busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst busy", 32'(busy8), 32'd0);
    check_eq("rst done", 32'(done8), 32'd0);
    check_eq("rst sum", 32'(sum8), 32'd0);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8) extra_done++;
      if (busy8) extra_busy++;
    end
    check_eq("rst no_done", 32'(extra_done), 32'd0);
    check_eq("rst no_busy", 32'(extra_busy), 32'd0);
    run_add8(8'h01, 8'h02, 9'h003, "01+02");

    // WIDTH=1, all pairs back-to-back at one add per three cycles
    for (int p = 0; p < 4; p++) begin
      a1 = 1'(p >> 1);
      b1 = 1'(p);
      exp1 = (p == 0) ? 2'b00 : (p == 3) ? 2'b10 : 2'b01;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1 = ~a1;
      check_eq($sformatf("w1 pair%0d busy", p), 32'(busy1), 32'd1);
      check_eq($sformatf("w1 pair%0d early_done", p), 32'(done1), 32'd0);
      tick();
      check_eq($sformatf("w1 pair%0d done", p), 32'(done1), 32'd1);
      check_eq($sformatf("w1 pair%0d sum", p), 32'(sum1), 32'(exp1));
      tick();
      check_eq($sformatf("w1 pair%0d done_fall", p), 32'(done1), 32'd0);
      check_eq($sformatf("w1 pair%0d busy_fall", p), 32'(busy1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit add cell, built from two half-adder stages and a carry flip-flop, over a WIDTH-bit operand pair, LSB first. It accepts an operand pair on a start pulse, runs one bit per clock, and presents a WIDTH+1-bit sum with a one-cycle done pulse. It sits between a requesting testbench or controller and the half-adder datapath, trading area for latency.

## Interface

- WIDTH, 8, operand width in bits; legal range 1 to 32.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to add a_in and b_in; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepted start edge.
- b_in  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high in ADD and DONE; start is ignored while high.
- done  output  1  one-cycle pulse marking sum_out as newly valid.
- sum_out  output  WIDTH+1  result {carry_out, sum[WIDTH-1:0]}; holds until the next done.

## Operation

- The synchronous, active-high reset is fixed for this block.
- States:
  - IDLE: waiting for start.
  - ADD: processing one bit per cycle.
  - DONE: result published.
- Internal registers:
  - a_sh, b_sh (WIDTH bits): operand shift registers.
  - acc (WIDTH bits): result shift register.
  - carry (1 bit).
  - cnt: bit counter, $clog2(WIDTH+1) bits.
- IDLE to ADD when start=1. On that edge: a_sh<=a_in, b_sh<=b_in, carry<=0, cnt<=0, acc<=0.
- ADD, each edge:
  - Stage 1 half adder on a_sh[0], b_sh[0] gives s1, c1.
  - Stage 2 half adder on s1, carry gives bit, c2.
  - carry<=c1|c2.
  - acc<={bit, acc[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one, zero-filled.
  - cnt<=cnt+1.
- ADD to DONE on the edge where cnt==WIDTH-1, which processes the last bit. On that same edge sum_out<={final carry, final acc value including this bit}.
- DONE to IDLE unconditionally on the next edge. start is ignored while in DONE.
- Arithmetic: sum_out = a_in + b_in, exact and unsigned, no overflow possible. Bit WIDTH is the final carry.
- start while busy is dropped, not queued. The operands in flight are unaffected.
- rst=1 on any edge, including mid-ADD, forces the following and discards the partial result:
  - state goes to IDLE.
  - busy=0, done=0, sum_out=0.
  - carry=0, cnt=0, a_sh=0, b_sh=0, acc=0.
- If rst and start are high on the same edge, rst wins.

## Timing

- Reset values: busy=0, done=0, sum_out=0.
- Start is accepted at edge E0. busy rises after E0.
- Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- done=1 and sum_out are valid in the cycle after edge E_WIDTH, that is WIDTH cycles after acceptance.
- done deasserts and busy falls after edge E_WIDTH+1. State is IDLE from then on.
- Earliest next acceptance is edge E_WIDTH+2, so throughput is one add per WIDTH+2 cycles.
- done is a registered output decoded from state==DONE, and is exactly 1 cycle wide.
- busy is registered and glitch-free.
- sum_out changes only on the DONE-entry edge or on reset.

## Test plan

- Reset, then idle with start=0 for 10 cycles -> busy=0, done=0, sum_out=0 throughout.
- WIDTH=8, a_in=0x5A, b_in=0x33, start pulse -> done exactly 8 cycles after acceptance; sum_out=0x08D; busy high for 9 cycles.
- WIDTH=8, carry chain cases:
  - 0xFF+0x01 -> sum_out=0x100.
  - 0xFF+0xFF -> sum_out=0x1FE.
  - 0x00+0x00 -> sum_out=0x000.
- Start 0x10+0x20, then pulse start with 0x7F+0x7F at cycles 3 and in DONE -> single done, sum_out=0x030, second request dropped.
- Start 0xAA+0x55, assert rst at cycle 4 of ADD -> next cycle busy=0, sum_out=0, no done pulse. A following start with 0x01+0x02 -> sum_out=0x003.
- WIDTH=1, all four input pairs back-to-back at the maximum rate -> sum_out 00, 01, 01, 10, each done 1 cycle after acceptance.
